// File: rtl/cv32e40s_sleep_ctrl.sv
// Sleep controller: drains outstanding bus traffic after WFI, parks the core in SLEEP,
// and walks it back to RUN through a fixed-length WAKE period on an interrupt or debug request.
module cv32e40s_sleep_ctrl #(
    parameter int WAKE_CYCLES = 2,
    parameter int SLEEP_CNT_W = 32
) (
    input  logic                   clk_ungated_i,
    input  logic                   rst,
    input  logic                   wfi_i,
    input  logic                   debug_mode_i,
    input  logic                   irq_pending_i,
    input  logic                   debug_req_i,
    input  logic                   if_busy_i,
    input  logic                   lsu_busy_i,
    output logic                   ctrl_busy_o,
    output logic                   wake_from_sleep_o,
    output logic                   sleep_o,
    output logic [SLEEP_CNT_W-1:0] sleep_cycles_o
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        SLEEP = 2'd2,
        WAKE  = 2'd3
    } state_t;

    localparam logic [3:0] WAKE_LOAD = 4'(WAKE_CYCLES - 1);

    state_t                 r_state;
    logic [3:0]             r_wake_cnt;
    logic [SLEEP_CNT_W-1:0] r_sleep_cnt;
    logic                   w_wake_evt;

    assign w_wake_evt = irq_pending_i || debug_req_i;

    // Four states fill the 2-bit encoding, so no illegal state is reachable.
    always_ff @(posedge clk_ungated_i) begin
        if (rst) begin
            r_state     <= RUN;
            r_wake_cnt  <= 4'd0;
            r_sleep_cnt <= '0;
        end else begin
            if (r_state == SLEEP && r_sleep_cnt != {SLEEP_CNT_W{1'b1}}) begin
                r_sleep_cnt <= r_sleep_cnt + SLEEP_CNT_W'(1);
            end
            case (r_state)
                RUN: begin
                    if (wfi_i && !debug_mode_i && !w_wake_evt) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_wake_evt) begin
                        r_state <= RUN;
                    end else if (!if_busy_i && !lsu_busy_i) begin
                        r_state <= SLEEP;
                    end
                end
                SLEEP: begin
                    if (w_wake_evt) begin
                        r_state    <= WAKE;
                        r_wake_cnt <= WAKE_LOAD;
                    end
                end
                WAKE: begin
                    if (r_wake_cnt == 4'd0) begin
                        r_state <= RUN;
                    end else begin
                        r_wake_cnt <= r_wake_cnt - 4'd1;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    // The SLEEP term bypasses the flops so the clock gate opens on the edge that sees the event.
    assign ctrl_busy_o       = (r_state != SLEEP);
    assign sleep_o           = (r_state == SLEEP);
    assign wake_from_sleep_o = ((r_state == SLEEP) && w_wake_evt) || (r_state == WAKE);
    assign sleep_cycles_o    = r_sleep_cnt;

endmodule

// File: tb/tb_cv32e40s_sleep_ctrl.sv
// Bench for cv32e40s_sleep_ctrl: directed scenarios plus random traffic, every cycle
// scored against a queue of expectations produced by a behavioural model.
module tb_cv32e40s_sleep_ctrl;

    localparam int WAKE_CYCLES = 2;
    localparam int SLEEP_CNT_W = 4;
    localparam int CNT_MAX     = (1 << SLEEP_CNT_W) - 1;

    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_SLEEP = 2;
    localparam int M_WAKE  = 3;

    typedef struct {
        int cycle;
        int busy;
        int wfs;
        int slp;
        int cnt;
    } exp_t;

    logic                   clk;
    logic                   rst;
    logic                   wfi;
    logic                   dbgMode;
    logic                   irq;
    logic                   dbgReq;
    logic                   ifBusy;
    logic                   lsuBusy;
    logic                   ctrlBusy;
    logic                   wakeFromSleep;
    logic                   sleepOut;
    logic [SLEEP_CNT_W-1:0] sleepCycles;

    exp_t expQ[$];
    int   total     = 0;
    int   bad       = 0;
    int   cycleNum  = 0;
    int   mMode     = M_RUN;
    int   mWakeLeft = 0;
    int   mCount    = 0;

    cv32e40s_sleep_ctrl #(
        .WAKE_CYCLES(WAKE_CYCLES),
        .SLEEP_CNT_W(SLEEP_CNT_W)
    ) dut (
        .clk_ungated_i    (clk),
        .rst              (rst),
        .wfi_i            (wfi),
        .debug_mode_i     (dbgMode),
        .irq_pending_i    (irq),
        .debug_req_i      (dbgReq),
        .if_busy_i        (ifBusy),
        .lsu_busy_i       (lsuBusy),
        .ctrl_busy_o      (ctrlBusy),
        .wake_from_sleep_o(wakeFromSleep),
        .sleep_o          (sleepOut),
        .sleep_cycles_o   (sleepCycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOne(input string name, input int cyc, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checkOne("ctrl_busy_o", e.cycle, int'(ctrlBusy), e.busy);
        checkOne("wake_from_sleep_o", e.cycle, int'(wakeFromSleep), e.wfs);
        checkOne("sleep_o", e.cycle, int'(sleepOut), e.slp);
        checkOne("sleep_cycles_o", e.cycle, int'(sleepCycles), e.cnt);
    endtask

    // One cycle: drive inputs, record what the outputs must be this cycle, then advance the model.
    task automatic applyStimulus(input logic w, input logic dm, input logic ir, input logic dr,
                                 input logic ib, input logic lb, input logic r);
        exp_t e;
        bit   wakeEvt;
        @(negedge clk);
        wfi = w; dbgMode = dm; irq = ir; dbgReq = dr; ifBusy = ib; lsuBusy = lb; rst = r;
        wakeEvt = ir || dr;
        e.cycle = cycleNum;
        e.busy  = (mMode == M_SLEEP) ? 0 : 1;
        e.slp   = (mMode == M_SLEEP) ? 1 : 0;
        e.wfs   = ((mMode == M_SLEEP && wakeEvt) || mMode == M_WAKE) ? 1 : 0;
        e.cnt   = mCount;
        expQ.push_back(e);
        cycleNum++;
        if (r) begin
            mMode = M_RUN; mWakeLeft = 0; mCount = 0;
        end else begin
            if (mMode == M_SLEEP && mCount < CNT_MAX) mCount = mCount + 1;
            if (mMode == M_RUN) begin
                if (w && !dm && !wakeEvt) mMode = M_DRAIN;
            end else if (mMode == M_DRAIN) begin
                if (wakeEvt) mMode = M_RUN;
                else if (!ib && !lb) mMode = M_SLEEP;
            end else if (mMode == M_SLEEP) begin
                if (wakeEvt) begin
                    mMode = M_WAKE; mWakeLeft = WAKE_CYCLES;
                end
            end else begin
                mWakeLeft = mWakeLeft - 1;
                if (mWakeLeft == 0) mMode = M_RUN;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: outputs are valid every cycle, so score each queued expectation shortly after the driving edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        int irqDiv;
        wfi = 0; dbgMode = 0; irq = 0; dbgReq = 0; ifBusy = 0; lsuBusy = 0; rst = 1;
        repeat (2) @(negedge clk);

        idle(2);
        // WFI with idle buses, then interrupt wake through WAKE back to RUN
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        idle(3);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        idle(4);
        // drain held by LSU for five cycles
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 1, 0);
        idle(2);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        idle(3);
        // interrupt during drain returns straight to RUN
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 1, 0);
        applyStimulus(0, 0, 1, 0, 1, 0, 0);
        idle(3);
        // WFI ignored in debug mode or alongside a wake event
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        idle(2);
        applyStimulus(1, 0, 0, 1, 0, 0, 0);
        idle(2);
        applyStimulus(1, 0, 1, 0, 0, 0, 0);
        idle(2);
        // long sleep saturates the counter
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        idle(22);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        idle(4);
        // reset in the first WAKE cycle
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        idle(3);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        idle(3);
        // reset mid-SLEEP
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        idle(4);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        idle(2);

        for (int blk = 0; blk < 30; blk++) begin
            irqDiv = int'($urandom_range(4, 40));
            for (int i = 0; i < 60; i++) begin
                applyStimulus(($urandom % 4) == 0, ($urandom % 10) == 0,
                              ($urandom % irqDiv) == 0, ($urandom % (irqDiv * 2)) == 0,
                              ($urandom % 3) == 0, ($urandom % 3) == 0,
                              ($urandom % 300) == 0);
            end
        end

        repeat (3) @(negedge clk);
        #3;
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain_queue actual=%0d required=0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cv32e40s_sleep_ctrl.md
CV32E40S_SLEEP_CTRL -- requirements
Module: cv32e40s_sleep_ctrl

Interface
REQ-001 Parameter WAKE_CYCLES, default 2, number of cycles (1..15) spent in WAKE before returning to RUN.
REQ-002 Parameter SLEEP_CNT_W, default 32, width of the sleep-cycle counter.
REQ-003 The block SHALL have exactly one clock and a synchronous, active-high reset, with these ports:
- clk_ungated_i  in  1  free-running clock; never gated; all state sampled on its rising edge.
- rst  in  1  synchronous, active-high reset.
- wfi_i  in  1  a WFI instruction retires this cycle (single-cycle pulse).
- debug_mode_i  in  1  core is in debug mode.
- irq_pending_i  in  1  an enabled interrupt is pending (level).
- debug_req_i  in  1  external debug request (level).
- if_busy_i  in  1  fetch stage has outstanding transactions.
- lsu_busy_i  in  1  LSU has outstanding transactions.
- ctrl_busy_o  out  1  controller requires clock; consumed by the sleep unit.
- wake_from_sleep_o  out  1  wake event; consumed combinationally by the sleep unit clock enable.
- sleep_o  out  1  core is in the SLEEP state.
- sleep_cycles_o  out  SLEEP_CNT_W  saturating count of cycles spent in SLEEP.

Function
REQ-004 The FSM SHALL have the states RUN, DRAIN, SLEEP and WAKE, and SHALL be encoded without illegal reachable states.
REQ-005 Define wake_evt = irq_pending_i || debug_req_i.
REQ-006 In RUN, the FSM SHALL go to DRAIN when wfi_i && !debug_mode_i && !wake_evt; otherwise it SHALL stay in RUN.
- A WFI in debug mode, or coincident with wake_evt, SHALL act as a NOP.
REQ-007 In DRAIN, if wake_evt is high, the FSM SHALL go to RUN; wake has priority over drain completion.
REQ-008 In DRAIN, if wake_evt is low and !if_busy_i && !lsu_busy_i, the FSM SHALL go to SLEEP; otherwise it SHALL stay in DRAIN with no timeout.
REQ-009 In SLEEP, the FSM SHALL go to WAKE on wake_evt.
REQ-010 In WAKE, a down-counter loaded with WAKE_CYCLES-1 on entry SHALL decrement each cycle, and the FSM SHALL go to RUN in the cycle after the counter reads 0.
- WAKE therefore lasts exactly WAKE_CYCLES cycles.
REQ-011 wake_evt SHALL NOT restart the WAKE counter, and wfi_i SHALL be ignored in every state except RUN.
REQ-012 ctrl_busy_o SHALL be 1 in RUN, DRAIN and WAKE, and 0 in SLEEP; it is decoded from registered state only.
REQ-013 wake_from_sleep_o SHALL equal (state==SLEEP && wake_evt) || state==WAKE.
- The SLEEP term is combinational, so the clock resumes on the same edge that wake_evt is sampled.
REQ-014 sleep_o SHALL be 1 iff state==SLEEP (registered decode).
REQ-015 sleep_cycles_o SHALL increment by 1 on each cycle with state==SLEEP, and SHALL saturate at all-ones with no wrap.
- It SHALL never be cleared except by reset.
REQ-016 No output SHALL depend combinationally on wfi_i, if_busy_i or lsu_busy_i.

Reset
REQ-017 While rst is high at a rising edge, state SHALL become RUN, the WAKE counter 0 and sleep_cycles_o 0.
- Outputs after reset SHALL be: ctrl_busy_o=1, wake_from_sleep_o=0, sleep_o=0, sleep_cycles_o=0.
REQ-018 Reset asserted in any state, including mid-WAKE or mid-SLEEP, SHALL take effect at the next edge and SHALL override all other transitions.
REQ-019 No flop SHALL have an asynchronous reset.

Verification
REQ-020 WFI with buses idle: wfi_i pulse at cycle 0 -> DRAIN at cycle 1, SLEEP at cycle 2, ctrl_busy_o=0 and sleep_o=1 at cycle 2.
REQ-021 Drain wait: wfi_i, then lsu_busy_i=1 for 5 cycles -> DRAIN held 5 cycles, SLEEP one cycle after lsu_busy_i falls; irq_pending_i raised during DRAIN -> RUN with sleep_cycles_o unchanged.
REQ-022 Wake: in SLEEP, irq_pending_i=1 -> wake_from_sleep_o=1 in the same cycle, WAKE for 2 cycles (default), then RUN with ctrl_busy_o=1.
REQ-023 NOP cases: wfi_i with debug_mode_i=1, or with debug_req_i=1 in the same cycle -> state remains RUN and sleep_o never asserts.
REQ-024 Saturation: SLEEP_CNT_W=4, hold SLEEP for 20 cycles -> sleep_cycles_o reaches 15 and holds at 15.
REQ-025 Reset mid-WAKE: rst=1 in the first WAKE cycle -> next cycle state RUN, sleep_cycles_o=0, wake_from_sleep_o=0.
